// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter width: $clog2(width), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced over WIDTH bits, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub_in port for a - b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_in,
`endif
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e          state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic            carry_q, cout_q;
    logic [CntW-1:0] cnt_q;
    logic            start_ready_q, busy_q, done_valid_q;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = fa_s;
    end

    always_comb begin
        b_load = b_in;
        c_load = cin_in;
`ifdef SERIAL_ADD_SUB_EN
        if (sub_in) begin
            b_load = ~b_in;
            c_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            sum_q         <= '0;
            carry_q       <= 1'b0;
            cout_q        <= 1'b0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        a_q           <= a_in;
                        b_q           <= b_load;
                        carry_q       <= c_load;
                        cnt_q         <= '0;
                        res_q         <= '0;
                        state_q       <= StRun;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                StRun: begin
                    res_q   <= res_shift;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q      <= StDone;
                        done_valid_q <= 1'b1;
                        sum_q        <= res_shift;
                        cout_q       <= fa_co;
                    end
                end
                StDone: begin
                    if (done_ready) begin
                        state_q       <= StIdle;
                        done_valid_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    done_valid_q  <= 1'b0;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done_valid  = done_valid_q;
    assign sum_out     = sum_q;
    assign cout_out    = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int MaxWait = 40;

    logic             clk;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_in;
`endif
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    int checks;
    int failures;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin_in      (cin_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub_in      (sub_in),
`endif
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum_out     (sum_out),
        .cout_out    (cout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one cycle; returns with the handshake edge just past (cycle 1).
    task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin);
        a_in        = a;
        b_in        = b;
        cin_in      = cin;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    // Cycles are numbered from the handshake cycle (0); returns the first cycle with done_valid.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_valid && cyc < MaxWait) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (start_ready !== 1'b1) begin failures++;
            $display("FAIL reset_start_ready got=%b want=1", start_ready); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done_valid !== 1'b0) begin failures++;
            $display("FAIL reset_done_valid got=%b want=0", done_valid); end
        checks++; if (sum_out !== 8'h00) begin failures++;
            $display("FAIL reset_sum got=%h want=00", sum_out); end
        checks++; if (cout_out !== 1'b0) begin failures++;
            $display("FAIL reset_cout got=%b want=0", cout_out); end
    endtask

    task automatic test_basic_latency();
        int cyc;
        done_ready = 1'b1;
        do_start(8'h0F, 8'h01, 1'b0);
        checks++; if (busy !== 1'b1 || start_ready !== 1'b0) begin failures++;
            $display("FAIL run_flags got busy=%b start_ready=%b want 1/0", busy, start_ready); end
        wait_done(cyc);
        checks++; if (cyc != WIDTH + 1) begin failures++;
            $display("FAIL latency got=%0d want=%0d", cyc, WIDTH + 1); end
        checks++; if (sum_out !== 8'h10 || cout_out !== 1'b0) begin failures++;
            $display("FAIL basic_sum got=%h/%b want=10/0", sum_out, cout_out); end
        step();
        checks++; if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done got dv=%b sr=%b busy=%b want 0/1/0",
                     done_valid, start_ready, busy); end
        checks++; if (sum_out !== 8'h10) begin failures++;
            $display("FAIL idle_hold_sum got=%h want=10", sum_out); end
    endtask

    task automatic test_add_vectors();
        logic [WIDTH-1:0] va [4] = '{8'hFF, 8'hFF, 8'h5A, 8'h80};
        logic [WIDTH-1:0] vb [4] = '{8'h01, 8'hFF, 8'hA5, 8'h80};
        logic             vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [WIDTH-1:0] es [4] = '{8'h00, 8'hFF, 8'hFF, 8'h01};
        logic             ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int cyc;
        done_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_start(va[i], vb[i], vc[i]);
            wait_done(cyc);
            checks++; if (done_valid !== 1'b1 || sum_out !== es[i] || cout_out !== ec[i]) begin
                failures++;
                $display("FAIL add_vec%0d got dv=%b sum=%h cout=%b want 1/%h/%b",
                         i, done_valid, sum_out, cout_out, es[i], ec[i]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        done_ready = 1'b0;
        do_start(8'h0F, 8'h01, 1'b0);
        wait_done(cyc);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (done_valid !== 1'b1 || sum_out !== 8'h10 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d got dv=%b sum=%h busy=%b want 1/10/1",
                         i, done_valid, sum_out, busy); end
        end
        done_ready = 1'b1;
        step();
        checks++; if (done_valid !== 1'b0 || start_ready !== 1'b1) begin failures++;
            $display("FAIL bp_release got dv=%b sr=%b want 0/1", done_valid, start_ready); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        done_ready = 1'b0;
        do_start(8'h0F, 8'h01, 1'b0);
        step();
        a_in        = 8'hAA;
        b_in        = 8'hAA;
        start_valid = 1'b1;
        checks++; if (start_ready !== 1'b0) begin failures++;
            $display("FAIL run_start_ready got=%b want=0", start_ready); end
        step();
        start_valid = 1'b0;
        wait_done(cyc);
        checks++; if (done_valid !== 1'b1 || sum_out !== 8'h10 || cout_out !== 1'b0) begin
            failures++;
            $display("FAIL ignore_run got dv=%b sum=%h cout=%b want 1/10/0",
                     done_valid, sum_out, cout_out); end
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        checks++; if (done_valid !== 1'b1 || start_ready !== 1'b0 || sum_out !== 8'h10) begin
            failures++;
            $display("FAIL ignore_done got dv=%b sr=%b sum=%h want 1/0/10",
                     done_valid, start_ready, sum_out); end
        done_ready = 1'b1;
        step();
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL ignore_idle got sr=%b busy=%b want 1/0", start_ready, busy); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        done_ready = 1'b1;
        do_start(8'hFF, 8'hFF, 1'b1);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags got sr=%b dv=%b busy=%b want 1/0/0",
                     start_ready, done_valid, busy); end
        checks++; if (sum_out !== 8'h00 || cout_out !== 1'b0) begin failures++;
            $display("FAIL midrst_result got=%h/%b want=00/0", sum_out, cout_out); end
        do_start(8'h03, 8'h04, 1'b0);
        wait_done(cyc);
        checks++; if (cyc != WIDTH + 1 || sum_out !== 8'h07 || cout_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_fresh got cyc=%0d sum=%h cout=%b want %0d/07/0",
                     cyc, sum_out, cout_out, WIDTH + 1); end
        step();
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_subtract();
        int cyc;
        done_ready = 1'b1;
        sub_in     = 1'b1;
        do_start(8'h05, 8'h07, 1'b0);
        wait_done(cyc);
        checks++; if (sum_out !== 8'hFE || cout_out !== 1'b0) begin failures++;
            $display("FAIL sub_borrow got=%h/%b want=FE/0", sum_out, cout_out); end
        step();
        do_start(8'h07, 8'h05, 1'b0);
        wait_done(cyc);
        checks++; if (sum_out !== 8'h02 || cout_out !== 1'b1) begin failures++;
            $display("FAIL sub_noborrow got=%h/%b want=02/1", sum_out, cout_out); end
        step();
        sub_in = 1'b0;
    endtask
`endif

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        a_in        = '0;
        b_in        = '0;
        cin_in      = 1'b0;
        done_ready  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_in      = 1'b0;
`endif
        test_reset();
        test_basic_latency();
        test_add_vectors();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
        test_subtract();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
